fp_div_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_round_unit.sv | 34 +++
 rtl/fp_div_seq.sv | 112 +++++++++++
 tb/tb_fp_div_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared FP32 field layout, rounding-mode codes and divider FSM states.
package fp_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
    localparam logic [30:0] MAX_FIN = 31'h7F7FFFFF;
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    typedef enum logic [2:0] {S_IDLE, S_DIV, S_NORM, S_ROUND, S_DONE} state_t;
endpackage

// File: rtl/fp_round_unit.sv
// fp_round_unit: rounds a normalised {sign, frac, G, S, E} to FP32 with overflow/flush handling.
module fp_round_unit
    import fp_pkg::*;
(
    input  logic                  sign_i,
    input  logic [FRAC_W-1:0]     frac_i,
    input  logic                  g_i,
    input  logic                  s_i,
    input  logic signed [9:0]     exp_i,
    input  logic [2:0]            r_mode_i,
    output logic [31:0]           fp_z_o,
    output logic                  ovrf_o,
    output logic                  udrf_o
);
    logic inc, carry, to_inf;
    logic [FRAC_W-1:0] frac_r;
    logic signed [9:0] e_r;
    always_comb begin
        inc = (r_mode_i == RM_RTZ) ? 1'b0 :
              (r_mode_i == RM_RDN) ? sign_i & (g_i | s_i) :
              (r_mode_i == RM_RUP) ? !sign_i & (g_i | s_i) :
              (r_mode_i == RM_RMM) ? g_i : g_i & (s_i | frac_i[0]);
        // a carry out of the all-ones fraction leaves frac 0 with the exponent bumped
        {carry, frac_r} = {1'b0, frac_i} + 24'(inc);
        e_r = exp_i + 10'(carry);
        ovrf_o = e_r >= 10'sd255;
        udrf_o = e_r <= 10'sd0;
        to_inf = (r_mode_i == RM_RTZ) ? 1'b0 :
                 (r_mode_i == RM_RDN) ? sign_i :
                 (r_mode_i == RM_RUP) ? !sign_i : 1'b1;
        fp_z_o = ovrf_o ? {sign_i, to_inf ? {EXP_INF, 23'd0} : MAX_FIN} :
                 udrf_o ? {sign_i, 31'd0} : {sign_i, e_r[EXP_W-1:0], frac_r};
    end
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential FP32 divider, restoring division retiring QBITS quotient bits per cycle.
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int          QBITS = 1,
    parameter logic [31:0] QNAN  = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        nv,
    output logic        dz
);
    localparam int ITERS = 26 / QBITS;
    state_t st_q;
    logic [EXP_W-1:0] ex, ey;
    logic x_zero, x_inf, x_nan, y_zero, y_inf, y_nan, sgn, special, spec_nv, spec_dz;
    logic [31:0] spec_z, r_z;
    logic sign_q, g_q, s_q, r_ovrf, r_udrf;
    logic [2:0] rm_q;
    logic [4:0] cnt_q;
    logic signed [9:0] e_q;
    logic [23:0] my_q;
    logic [25:0] rem_q, rem_d, quo_q, quo_d;
    logic [FRAC_W-1:0] frac_q;
    assign ex = fp_X[FRAC_W+:EXP_W];
    assign ey = fp_Y[FRAC_W+:EXP_W];
    assign x_zero = ex == '0;
    assign y_zero = ey == '0;
    assign x_inf = ex == EXP_INF && fp_X[FRAC_W-1:0] == '0;
    assign y_inf = ey == EXP_INF && fp_Y[FRAC_W-1:0] == '0;
    assign x_nan = ex == EXP_INF && fp_X[FRAC_W-1:0] != '0;
    assign y_nan = ey == EXP_INF && fp_Y[FRAC_W-1:0] != '0;
    assign sgn = fp_X[31] ^ fp_Y[31];
    assign special = x_zero | x_inf | x_nan | y_zero | y_inf | y_nan;
    assign spec_nv = !x_nan && !y_nan && ((x_zero && y_zero) || (x_inf && y_inf));
    assign spec_dz = y_zero && !x_zero && !x_inf && !x_nan;
    assign spec_z = (x_nan || y_nan || spec_nv) ? QNAN :
                    (x_inf || y_zero) ? {sgn, EXP_INF, 23'd0} : {sgn, 31'd0};
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        for (int k = 0; k < QBITS; k++) begin
            quo_d = {quo_d[24:0], rem_d >= {2'b0, my_q}};
            rem_d = (quo_d[0] ? rem_d - {2'b0, my_q} : rem_d) << 1;
        end
    end
    fp_round_unit u_round (
        .sign_i(sign_q), .frac_i(frac_q), .g_i(g_q), .s_i(s_q), .exp_i(e_q),
        .r_mode_i(rm_q), .fp_z_o(r_z), .ovrf_o(r_ovrf), .udrf_o(r_udrf)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= S_IDLE;
            {busy, done, fp_Z, ovrf, udrf, nv, dz} <= '0;
            {sign_q, g_q, s_q, rm_q, cnt_q, e_q, my_q, rem_q, quo_q, frac_q} <= '0;
        end else begin
            done <= 1'b0;
            case (st_q)
                S_IDLE: if (start) begin
                    busy <= 1'b1;
                    sign_q <= sgn;
                    rm_q <= r_mode;
                    {ovrf, udrf} <= 2'b00;
                    nv <= special & spec_nv;
                    dz <= special & spec_dz;
                    if (special) fp_Z <= spec_z;
                    e_q <= {2'b0, ex} - {2'b0, ey} + 10'(BIAS);
                    my_q <= {1'b1, fp_Y[FRAC_W-1:0]};
                    rem_q <= {3'b001, fp_X[FRAC_W-1:0]};
                    quo_q <= '0;
                    cnt_q <= '0;
                    st_q <= special ? S_DONE : S_DIV;
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(ITERS - 1)) st_q <= S_NORM;
                end
                S_NORM: begin
                    // quotient in [2^24, 2^26): keep 24 significant bits, fold the rest into G/S
                    frac_q <= quo_q[25] ? quo_q[24:2] : quo_q[23:1];
                    g_q <= quo_q[25] ? quo_q[1] : quo_q[0];
                    s_q <= (quo_q[25] & quo_q[0]) | (|rem_q);
                    e_q <= quo_q[25] ? e_q : e_q - 10'sd1;
                    st_q <= S_ROUND;
                end
                S_ROUND: begin
                    fp_Z <= r_z;
                    ovrf <= r_ovrf;
                    udrf <= r_udrf;
                    st_q <= S_DONE;
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    st_q <= S_IDLE;
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: randomized and directed checks of fp_div_seq against an exact-arithmetic model.
module tb_fp_div_seq;
    localparam int QB = 1;
    localparam int P = 10;
    localparam int NLAT = 26 / QB + 3;
    typedef struct {
        logic [31:0] z;
        logic [3:0]  fl;
        int          lat;
        longint      t;
    } exp_t;
    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
    } op_t;
    logic clk = 0, rst = 1, start = 0;
    logic [31:0] fp_X = 0, fp_Y = 0;
    logic [2:0] r_mode = 0;
    logic busy, done, ovrf, udrf, nv, dz;
    logic [31:0] fp_Z;
    int n_chk = 0, n_fail = 0;
    exp_t q[$];
    fp_div_seq #(.QBITS(QB)) dut (
        .clk(clk), .rst(rst), .start(start), .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode),
        .busy(busy), .done(done), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf), .nv(nv), .dz(dz)
    );
    always #(P/2) clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
        n_chk++;
        if (a !== b) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", n, a, b);
        end
    endtask
    // Exact quotient via integer division; rounding decided by comparing the discarded part to one half.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm_in);
        exp_t r;
        logic s;
        int ex, ey, e, sh;
        logic xz, yz, xi, yi, xn, yn, up, to_inf;
        longint mx, my, num, qq, rr, m, r2, half;
        logic [2:0] rm;
        rm = (rm_in > 3'd4) ? 3'd0 : rm_in;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        s = x[31] ^ y[31];
        xz = ex == 0; yz = ey == 0;
        xi = ex == 255 && x[22:0] == 0; yi = ey == 255 && y[22:0] == 0;
        xn = ex == 255 && x[22:0] != 0; yn = ey == 255 && y[22:0] != 0;
        r.lat = 1; r.t = 0; r.fl = 4'b0000;
        if (xn || yn) r.z = 32'h7FC00000;
        else if ((xz && yz) || (xi && yi)) begin r.z = 32'h7FC00000; r.fl = 4'b0010; end
        else if (xi) r.z = {s, 31'h7F800000};
        else if (yi) r.z = {s, 31'd0};
        else if (yz) begin r.z = {s, 31'h7F800000}; r.fl = 4'b0001; end
        else if (xz) r.z = {s, 31'd0};
        else begin
            r.lat = NLAT;
            mx = longint'({1'b1, x[22:0]}); my = longint'({1'b1, y[22:0]});
            num = mx << 25;
            qq = num / my; rr = num % my;
            e = ex - ey + 127;
            sh = (qq >= (longint'(1) << 25)) ? 2 : 1;
            if (sh == 1) e--;
            m = qq >> sh;
            r2 = (qq % (longint'(1) << sh)) * my + rr;
            half = (longint'(1) << (sh - 1)) * my;
            case (rm)
                3'd1: up = 0;
                3'd2: up = s && r2 != 0;
                3'd3: up = !s && r2 != 0;
                3'd4: up = r2 >= half;
                default: up = r2 > half || (r2 == half && m[0]);
            endcase
            if (up) m++;
            if (m == (longint'(1) << 24)) begin m = longint'(1) << 23; e++; end
            to_inf = rm == 0 || rm == 4 || (rm == 2 && s) || (rm == 3 && !s);
            if (e >= 255) begin
                r.fl = 4'b1000;
                r.z = to_inf ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
            end else if (e <= 0) begin
                r.fl = 4'b0100;
                r.z = {s, 31'd0};
            end else r.z = {s, e[7:0], m[22:0]};
        end
        return r;
    endfunction
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_done: got done=1 required no pending operation");
            end else begin
                e = q.pop_front();
                chk("fp_Z", fp_Z, e.z);
                chk("flags{ovrf,udrf,nv,dz}", {28'd0, ovrf, udrf, nv, dz}, {28'd0, e.fl});
                chk("latency", 32'(($time - P/2 - e.t) / P), 32'(e.lat));
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
        exp_t e;
        @(negedge clk);
        fp_X = x; fp_Y = y; r_mode = rm; start = 1;
        e = model(x, y, rm);
        e.t = $time + P/2;
        q.push_back(e);
        @(negedge clk);
        start = 0;
        fp_X = $urandom; fp_Y = $urandom; r_mode = 3'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 3 * NLAT && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: got no done within %0d cycles required done", 3 * NLAT);
            q.delete();
        end
    endtask
    task automatic run(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
        issue(x, y, rm);
        wait_idle();
    endtask
    initial begin
        exp_t m;
        op_t dir [15];
        logic [31:0] x, y;
        dir = '{
            '{32'h40C00000, 32'h40400000, 3'd0}, '{32'h3F800000, 32'h40400000, 3'd0},
            '{32'h3F800000, 32'h40400000, 3'd1}, '{32'h3F800000, 32'h40400000, 3'd2},
            '{32'h3F800000, 32'h40400000, 3'd3}, '{32'hBF800000, 32'h40400000, 3'd2},
            '{32'h3F800000, 32'h00000000, 3'd0}, '{32'h00000000, 32'h80000000, 3'd0},
            '{32'h7FC00001, 32'h3F800000, 3'd0}, '{32'h7F000000, 32'h3E800000, 3'd0},
            '{32'h7F000000, 32'h3E800000, 3'd1}, '{32'h00800000, 32'h40000000, 3'd0},
            '{32'h3FFFFFFF, 32'h3F800001, 3'd4}, '{32'hFF800000, 32'h7F800000, 3'd0},
            '{32'h3F800000, 32'h40400000, 3'd6}
        };
        repeat (2) @(negedge clk);
        chk("reset_fp_Z", fp_Z, 32'd0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
        chk("reset_flags", {28'd0, ovrf, udrf, nv, dz}, 32'd0);
        rst = 0;
        m = model(32'h40C00000, 32'h40400000, 3'd0);
        chk("pin_6div3", m.z, 32'h40000000); chk("pin_6div3_lat", 32'(m.lat), 32'd29);
        m = model(32'h3F800000, 32'h40400000, 3'd0); chk("pin_third_rne", m.z, 32'h3EAAAAAB);
        m = model(32'h3F800000, 32'h40400000, 3'd1); chk("pin_third_rtz", m.z, 32'h3EAAAAAA);
        m = model(32'h3F800000, 32'h40400000, 3'd2); chk("pin_third_rdn", m.z, 32'h3EAAAAAA);
        m = model(32'h3F800000, 32'h40400000, 3'd3); chk("pin_third_rup", m.z, 32'h3EAAAAAB);
        m = model(32'hBF800000, 32'h40400000, 3'd2); chk("pin_mthird_rdn", m.z, 32'hBEAAAAAB);
        m = model(32'h3F800000, 32'h00000000, 3'd0);
        chk("pin_div0", {m.z[31:4], m.fl}, {28'h7F80000, 4'b0001});
        m = model(32'h00000000, 32'h80000000, 3'd0);
        chk("pin_0div0", {m.z[31:4], m.fl}, {28'h7FC0000, 4'b0010});
        m = model(32'h7F000000, 32'h3E800000, 3'd1);
        chk("pin_ovf_rtz", {m.z[31:4], m.fl}, {28'h7F7FFFF, 4'b1000});
        m = model(32'h00800000, 32'h40000000, 3'd0);
        chk("pin_udf", {m.z[31:4], m.fl}, {28'h0000000, 4'b0100});
        foreach (dir[i]) run(dir[i].x, dir[i].y, dir[i].rm);
        // second start mid-division must be ignored
        issue(32'h40C00000, 32'h40400000, 3'd0);
        repeat (5) @(negedge clk);
        fp_X = 32'h3F800000; fp_Y = 32'h40400000; start = 1;
        @(negedge clk);
        start = 0;
        wait_idle();
        repeat (NLAT + 2) @(negedge clk);
        // asynchronous reset mid-operation
        issue(32'h3F800000, 32'h40400000, 3'd0);
        repeat (9) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_fp_Z", fp_Z, 32'd0);
        q.delete();
        @(negedge clk);
        rst = 0;
        run(32'h40C00000, 32'h40400000, 3'd0);
        for (int i = 0; i < 150; i++) begin
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 9))
                0: x[30:23] = 8'h00;
                1: y[30:23] = 8'hFF;
                2: y[30:23] = 8'h00;
                3: x[30:23] = 8'hFF;
                4: begin x[30:23] = 8'($urandom_range(240, 254)); y[30:23] = 8'($urandom_range(1, 20)); end
                5: begin x[30:23] = 8'($urandom_range(1, 10)); y[30:23] = 8'($urandom_range(120, 254)); end
                6: begin x[30:23] = 8'($urandom_range(100, 150)); y[30:23] = 8'($urandom_range(100, 150)); end
                default: ;
            endcase
            run(x, y, 3'($urandom));
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1);
    end
endmodule
